// File: rtl/shreg_pkg.sv
// Shared constants, sample type and sizing helpers for the multi-channel
// sample-window shift register.
package shreg_pkg;

  localparam int DWIDTH_D = 15;
  localparam int UNR_D    = 4;
  localparam int NTAPS_D  = 37;

  typedef logic [DWIDTH_D-1:0] sample_t;

  // Integer ceiling division, used to size the number of beats per window fill.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 32'sd1) / den;
  endfunction

  // Channel index width; a single channel still gets a one-bit index.
  function automatic int chan_width(input int nch);
    return (nch > 32'sd1) ? $clog2(nch) : 32'sd1;
  endfunction

endpackage

// File: rtl/shreg_lane.sv
// One channel's sample window plus its saturating fill counter.
// win_next/full_next present the state this lane would take on a shift,
// so the top can register the updated window on the same edge.
module shreg_lane
  import shreg_pkg::*;
#(
  parameter int  DWIDTH    = DWIDTH_D,
  parameter int  UNR       = UNR_D,
  parameter int  NTAPS     = NTAPS_D,
  localparam int BUFLEN    = NTAPS - 1 + UNR,
  localparam int FILLBEATS = ceil_div(BUFLEN, UNR)
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           clr,
  input  logic                           shift_en,
  input  logic [UNR-1:0][DWIDTH-1:0]     din,
  output logic [BUFLEN-1:0][DWIDTH-1:0]  win_next,
  output logic                           full_next
);

  localparam int FCW = $clog2(FILLBEATS + 1);
  localparam logic [FCW-1:0] FILL_MAX = FCW'(FILLBEATS);

  logic [BUFLEN-1:0][DWIDTH-1:0] win_r;
  logic [BUFLEN-1:0][DWIDTH-1:0] shifted_s;
  logic [FCW-1:0]                fill_r;
  logic [FCW-1:0]                fill_inc_s;

  // New samples enter at the low slots; the oldest samples fall off the top.
  for (genvar k = 0; k < UNR; k++) begin : g_new
    assign shifted_s[k] = din[k];
  end
  for (genvar k = UNR; k < BUFLEN; k++) begin : g_old
    assign shifted_s[k] = win_r[k-UNR];
  end

  // Fill counter advances per beat and saturates once the window is full.
  always_comb begin
    fill_inc_s = fill_r;
    if (fill_r == FILL_MAX) begin
      fill_inc_s = fill_r;
    end else begin
      fill_inc_s = fill_r + FCW'(1'b1);
    end
  end

  assign win_next  = shifted_s;
  assign full_next = (fill_inc_s == FILL_MAX);

  // Window and fill state: async reset, sync clear, shift on enable.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      win_r  <= '0;
      fill_r <= '0;
    end else if (clr) begin
      win_r  <= '0;
      fill_r <= '0;
    end else if (shift_en) begin
      win_r  <= shifted_s;
      fill_r <= fill_inc_s;
    end else begin
      win_r  <= win_r;
      fill_r <= fill_r;
    end
  end

endmodule

// File: rtl/shreg_mc.sv
// Multi-channel sample-window shift register. Each accepted beat shifts UNR
// new samples into one channel's window; the updated window is registered
// onto dout together with its channel tag and a window-full flag.
module shreg_mc
  import shreg_pkg::*;
#(
  parameter int  DWIDTH = DWIDTH_D,
  parameter int  UNR    = UNR_D,
  parameter int  NTAPS  = NTAPS_D,
  parameter int  NCH    = 1,
  localparam int BUFLEN = NTAPS - 1 + UNR,
  localparam int CHW    = chan_width(NCH)
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           clr,
  input  logic                           in_valid,
  input  logic [CHW-1:0]                 in_ch,
  input  logic [UNR-1:0][DWIDTH-1:0]     din,
  output logic                           out_valid,
  output logic [CHW-1:0]                 out_ch,
  output logic                           out_full,
  output logic [BUFLEN-1:0][DWIDTH-1:0]  dout
);

  localparam logic [CHW:0] NCH_LIM = (CHW + 1)'(NCH);

  logic                                    ch_ok_s;
  logic                                    accept_s;
  logic [NCH-1:0]                          shift_en_s;
  logic [NCH-1:0][BUFLEN-1:0][DWIDTH-1:0]  lane_win_s;
  logic [NCH-1:0]                          lane_full_s;
  logic [BUFLEN-1:0][DWIDTH-1:0]           sel_win_s;
  logic                                    sel_full_s;

  logic                                    out_valid_r;
  logic [CHW-1:0]                          out_ch_r;
  logic                                    out_full_r;
  logic [BUFLEN-1:0][DWIDTH-1:0]           dout_r;

  // A beat counts only for an existing channel and never alongside a clear.
  assign ch_ok_s  = ({1'b0, in_ch} < NCH_LIM);
  assign accept_s = in_valid & ~clr & ch_ok_s;

  // One-hot shift enable for the addressed lane.
  always_comb begin
    shift_en_s = '0;
    for (int c = 0; c < NCH; c++) begin
      if (accept_s && (in_ch == CHW'(c))) begin
        shift_en_s[c] = 1'b1;
      end else begin
        shift_en_s[c] = 1'b0;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    shreg_lane #(
      .DWIDTH (DWIDTH),
      .UNR    (UNR),
      .NTAPS  (NTAPS)
    ) u_lane (
      .CLK       (CLK),
      .RST       (RST),
      .clr       (clr),
      .shift_en  (shift_en_s[c]),
      .din       (din),
      .win_next  (lane_win_s[c]),
      .full_next (lane_full_s[c])
    );
  end

  // AND-OR mux picking the addressed lane's post-shift window and full flag.
  always_comb begin
    sel_win_s  = '0;
    sel_full_s = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      sel_win_s  = sel_win_s
                 | (lane_win_s[c] & {(BUFLEN*DWIDTH){in_ch == CHW'(c)}});
      sel_full_s = sel_full_s | (lane_full_s[c] & (in_ch == CHW'(c)));
    end
  end

  // Output register: load on an accepted beat, zero on clear, hold otherwise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      out_full_r  <= 1'b0;
      dout_r      <= '0;
    end else if (clr) begin
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      out_full_r  <= 1'b0;
      dout_r      <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_ch_r    <= in_ch;
      out_full_r  <= sel_full_s;
      dout_r      <= sel_win_s;
    end else begin
      out_valid_r <= 1'b0;
      out_ch_r    <= out_ch_r;
      out_full_r  <= out_full_r;
      dout_r      <= dout_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_ch    = out_ch_r;
  assign out_full  = out_full_r;
  assign dout      = dout_r;

endmodule
